ufm_save: RTL and testbench

UFM_SAVE -- requirements
Module: ufm_save

---
 rtl/ufm_save.sv | 218 +++++++++++++++++++++
 tb/tb_ufm_save.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ufm_save.sv
// ufm_save: writes six packed configuration words to UFM sector 1.
// Sequence: unprotect, erase, program words 0-5 with status polling, re-protect.
module ufm_save #(
    parameter logic [19:0] TIMEOUT = 20'hFFFFF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    output logic [2:0]  word_idx,
    input  logic [31:0] word_data,
    output logic        csr_addr,
    output logic        csr_read,
    output logic        csr_write,
    output logic [31:0] csr_writedata,
    input  logic [31:0] csr_readdata,
    output logic [15:0] data_addr,
    output logic        data_write,
    output logic [31:0] data_writedata,
    input  logic        data_waitrequest,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [1:0]  err_code
);
    localparam int unsigned CNT_W  = 20;
    localparam int unsigned IDX_W  = 3;
    localparam int unsigned ADDR_W = 16;
    localparam logic [IDX_W-1:0] LAST_IDX = 3'd5;

    localparam logic [31:0] CTRL_UNPROT = 32'hFF7F_FFFF;
    localparam logic [31:0] CTRL_ERASE  = 32'hFF1F_FFFF;
    localparam logic [31:0] CTRL_PROT   = 32'hFFFF_FFFF;

    localparam logic [1:0] EC_OK      = 2'b00;
    localparam logic [1:0] EC_ERASE   = 2'b01;
    localparam logic [1:0] EC_WRITE   = 2'b10;
    localparam logic [1:0] EC_TIMEOUT = 2'b11;

    typedef enum logic [3:0] {
        IDLE, UNPROT, ERASE, E_POLL, E_CHK, WR, W_POLL, W_CHK, PROT, FIN
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  poll_cnt_q, poll_cnt_d, poll_inc;
    logic [IDX_W-1:0]  word_idx_q, word_idx_d;
    logic [1:0]        err_code_q, err_code_d;
    logic              error_q, error_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              csr_addr_q, csr_addr_d;
    logic              csr_read_q, csr_read_d;
    logic              csr_write_q, csr_write_d;
    logic [31:0]       csr_wdata_q, csr_wdata_d;
    logic [ADDR_W-1:0] data_addr_q, data_addr_d;
    logic              data_write_q, data_write_d;
    logic              flash_busy;
    logic              unused_status;

    // Status word: [1:0] busy, [3] write success, [4] erase success.
    assign flash_busy    = (csr_readdata[1:0] != 2'b00);
    assign unused_status = ^{csr_readdata[31:5], csr_readdata[2]};
    assign poll_inc      = poll_cnt_q + CNT_W'(1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            poll_cnt_q   <= '0;
            word_idx_q   <= '0;
            err_code_q   <= EC_OK;
            error_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            csr_addr_q   <= 1'b0;
            csr_read_q   <= 1'b0;
            csr_write_q  <= 1'b0;
            csr_wdata_q  <= '0;
            data_addr_q  <= '0;
            data_write_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            poll_cnt_q   <= poll_cnt_d;
            word_idx_q   <= word_idx_d;
            err_code_q   <= err_code_d;
            error_q      <= error_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            csr_addr_q   <= csr_addr_d;
            csr_read_q   <= csr_read_d;
            csr_write_q  <= csr_write_d;
            csr_wdata_q  <= csr_wdata_d;
            data_addr_q  <= data_addr_d;
            data_write_q <= data_write_d;
        end
    end

    // Next state; a poll is the E_POLL/W_POLL read cycle plus the CHK sample cycle.
    always_comb begin
        state_d    = state_q;
        poll_cnt_d = poll_cnt_q;
        word_idx_d = word_idx_q;
        err_code_d = err_code_q;
        error_d    = error_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = UNPROT;
                    word_idx_d = '0;
                    err_code_d = EC_OK;
                    error_d    = 1'b0;
                end
            end
            UNPROT: state_d = ERASE;
            ERASE: begin
                state_d    = E_POLL;
                poll_cnt_d = '0;
            end
            E_POLL: state_d = E_CHK;
            E_CHK: begin
                if (flash_busy) begin
                    poll_cnt_d = poll_inc;
                    if (poll_inc >= TIMEOUT) begin
                        err_code_d = EC_TIMEOUT;
                        state_d    = PROT;
                    end else begin
                        state_d = E_POLL;
                    end
                end else if (csr_readdata[4]) begin
                    state_d = WR;
                end else begin
                    err_code_d = EC_ERASE;
                    state_d    = PROT;
                end
            end
            WR: begin
                if (!data_waitrequest) begin
                    state_d    = W_POLL;
                    poll_cnt_d = '0;
                end
            end
            W_POLL: state_d = W_CHK;
            W_CHK: begin
                if (flash_busy) begin
                    poll_cnt_d = poll_inc;
                    if (poll_inc >= TIMEOUT) begin
                        err_code_d = EC_TIMEOUT;
                        state_d    = PROT;
                    end else begin
                        state_d = W_POLL;
                    end
                end else if (!csr_readdata[3]) begin
                    err_code_d = EC_WRITE;
                    state_d    = PROT;
                end else if (word_idx_q < LAST_IDX) begin
                    word_idx_d = word_idx_q + IDX_W'(1);
                    state_d    = WR;
                end else begin
                    state_d = PROT;
                end
            end
            PROT: begin
                state_d = FIN;
                error_d = (err_code_q != EC_OK);
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Bus strobes are decoded from the next state so they register in step with it.
    always_comb begin
        csr_addr_d   = 1'b0;
        csr_read_d   = 1'b0;
        csr_write_d  = 1'b0;
        csr_wdata_d  = '0;
        data_write_d = 1'b0;
        data_addr_d  = '0;
        busy_d       = (state_d != IDLE);
        done_d       = (state_d == FIN);
        case (state_d)
            UNPROT: begin
                csr_write_d = 1'b1;
                csr_addr_d  = 1'b1;
                csr_wdata_d = CTRL_UNPROT;
            end
            ERASE: begin
                csr_write_d = 1'b1;
                csr_addr_d  = 1'b1;
                csr_wdata_d = CTRL_ERASE;
            end
            PROT: begin
                csr_write_d = 1'b1;
                csr_addr_d  = 1'b1;
                csr_wdata_d = CTRL_PROT;
            end
            E_POLL, W_POLL: csr_read_d = 1'b1;
            WR: begin
                data_write_d = 1'b1;
                data_addr_d  = ADDR_W'(word_idx_d);
            end
            default: ;
        endcase
    end

    assign word_idx      = word_idx_q;
    assign err_code      = err_code_q;
    assign error         = error_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign csr_addr      = csr_addr_q;
    assign csr_read      = csr_read_q;
    assign csr_write     = csr_write_q;
    assign csr_writedata = csr_wdata_q;
    assign data_addr     = data_addr_q;
    assign data_write    = data_write_q;
    // word_data tracks word_idx combinationally, so it is passed through while writing.
    assign data_writedata = data_write_q ? word_data : '0;

endmodule

// File: tb/tb_ufm_save.sv
// tb_ufm_save: randomized flash/packer environment around ufm_save with a
// transaction-level expectation model and per-cycle bus protocol checks.
`timescale 1ns/1ps
module tb_ufm_save;
    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  word_idx;
    logic [31:0] word_data;
    logic        csr_addr, csr_read, csr_write;
    logic [31:0] csr_writedata;
    logic [31:0] csr_readdata = 32'h0;
    logic [15:0] data_addr;
    logic        data_write;
    logic [31:0] data_writedata;
    logic        data_waitrequest = 1'b0;
    logic        busy, done, error;
    logic [1:0]  err_code;

    ufm_save #(.TIMEOUT(20'd16)) dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .word_idx(word_idx), .word_data(word_data),
        .csr_addr(csr_addr), .csr_read(csr_read), .csr_write(csr_write),
        .csr_writedata(csr_writedata), .csr_readdata(csr_readdata),
        .data_addr(data_addr), .data_write(data_write),
        .data_writedata(data_writedata), .data_waitrequest(data_waitrequest),
        .busy(busy), .done(done), .error(error), .err_code(err_code)
    );

    always #5 clk = ~clk;

    // Scenario configuration
    logic [31:0] wv [6];
    bit          cfg_stuck = 0;
    bit          cfg_eok = 1;
    int          cfg_ebusy = 0;
    int          cfg_wbusy [6];
    bit          cfg_wok [6];
    int          cfg_wait [6];

    // Packer: word for the current index
    assign word_data = (word_idx < 3'd6) ? wv[word_idx] : 32'h0;

    // Observation logs
    int          tests = 0;
    int          fails = 0;
    logic [31:0] csr_log [$];
    logic [15:0] dw_addr_log [$];
    logic [31:0] dw_data_log [$];
    int          n_polls = 0, seq_cyc = 0, done_cnt = 0, hold2 = 0;
    logic [1:0]  ec_at_done = 2'b00;
    logic        err_at_done = 1'b0;

    // Environment state
    int          busy_left = 0, wait_left = 0, cur_w = 0, nact = 0, k = 0;
    bit          in_write = 0, prev_hold = 0;
    logic [15:0] prev_addr = 16'h0;
    logic [31:0] prev_data = 32'h0, st = 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Flash model, waitrequest driver and per-cycle protocol checks
    always @(negedge clk) begin
        if (!reset_n) begin
            in_write = 0; busy_left = 0; wait_left = 0; prev_hold = 0;
            data_waitrequest = 1'b0;
        end else begin
            nact = int'(csr_read) + int'(csr_write) + int'(data_write);
            chk("one_strobe", 32'(nact <= 1), 32'd1);
            if (csr_write) begin
                chk("csr_wr_addr", 32'(csr_addr), 32'd1);
                csr_log.push_back(csr_writedata);
                if (csr_writedata == 32'hFF1F_FFFF) busy_left = cfg_ebusy;
            end
            if (csr_read) begin
                chk("csr_rd_addr", 32'(csr_addr), 32'd0);
                n_polls++;
                st = $urandom;
                st[4] = cfg_eok;
                st[3] = cfg_wok[cur_w];
                if (cfg_stuck) st[1:0] = 2'b10;
                else if (busy_left > 0) begin
                    busy_left--;
                    st[1:0] = 2'($urandom_range(1, 3));
                end else st[1:0] = 2'b00;
                csr_readdata = st;
            end
            if (prev_hold) begin
                chk("hold_strobe", 32'(data_write), 32'd1);
                chk("hold_addr", 32'(data_addr), 32'(prev_addr));
                chk("hold_data", data_writedata, prev_data);
            end
            prev_hold = 0;
            if (data_write) begin
                k = dw_addr_log.size();
                chk("dw_addr", 32'(data_addr), 32'(k));
                chk("dw_data", data_writedata, (k < 6) ? wv[k] : 32'hDEAD_BEEF);
                if (data_addr == 16'd2) hold2++;
                if (!in_write) begin
                    in_write = 1;
                    wait_left = (k < 6) ? cfg_wait[k] : 0;
                end
                if (wait_left > 0) begin
                    wait_left--;
                    data_waitrequest = 1'b1;
                    prev_hold = 1; prev_addr = data_addr; prev_data = data_writedata;
                end else begin
                    data_waitrequest = 1'b0;
                    in_write = 0;
                    dw_addr_log.push_back(data_addr);
                    dw_data_log.push_back(data_writedata);
                    cur_w = (k < 6) ? k : 0;
                    busy_left = (k < 6) ? cfg_wbusy[k] : 0;
                end
            end else begin
                data_waitrequest = 1'($urandom_range(0, 1));
            end
            if (busy || done) seq_cyc++;
            if (done) begin
                done_cnt++;
                ec_at_done = err_code;
                err_at_done = error;
            end
        end
    end

    // Expected outcome from the scenario configuration
    task automatic model(output int nw, output logic [1:0] ec, output int lat, output int polls);
        int pe;
        nw = 0; ec = 2'b00; lat = 4; polls = 0;
        pe = cfg_stuck ? TO + 1 : cfg_ebusy + 1;
        if (pe > TO) begin ec = 2'b11; polls = TO; lat += 2 * TO; return; end
        polls = pe; lat += 2 * pe;
        if (!cfg_eok) begin ec = 2'b01; return; end
        for (int w = 0; w < 6; w++) begin
            int pw;
            pw = cfg_wbusy[w] + 1;
            nw = w + 1;
            lat += cfg_wait[w] + 1;
            if (pw > TO) begin ec = 2'b11; polls += TO; lat += 2 * TO; return; end
            polls += pw; lat += 2 * pw;
            if (!cfg_wok[w]) begin ec = 2'b10; return; end
        end
    endtask

    task automatic clear_logs();
        csr_log.delete(); dw_addr_log.delete(); dw_data_log.delete();
        n_polls = 0; seq_cyc = 0; done_cnt = 0; hold2 = 0;
    endtask

    task automatic set_good();
        cfg_stuck = 0; cfg_eok = 1; cfg_ebusy = 0;
        for (int i = 0; i < 6; i++) begin
            cfg_wbusy[i] = 0; cfg_wok[i] = 1; cfg_wait[i] = 0; wv[i] = $urandom;
        end
    endtask

    task automatic set_random();
        cfg_stuck = ($urandom_range(0, 19) == 0);
        cfg_eok = ($urandom_range(0, 9) != 0);
        cfg_ebusy = $urandom_range(0, 5);
        for (int i = 0; i < 6; i++) begin
            cfg_wbusy[i] = ($urandom_range(0, 39) == 0) ? 16 : int'($urandom_range(0, 5));
            cfg_wok[i] = ($urandom_range(0, 14) != 0);
            cfg_wait[i] = $urandom_range(0, 3);
            wv[i] = $urandom;
        end
    endtask

    task automatic check_rst(input string tag);
        chk({tag, "_strobes"}, 32'({csr_read, csr_write, data_write, csr_addr}), 32'd0);
        chk({tag, "_status"}, 32'({busy, done, error, err_code}), 32'd0);
        chk({tag, "_word_idx"}, 32'(word_idx), 32'd0);
        chk({tag, "_csr_wdata"}, csr_writedata, 32'd0);
        chk({tag, "_data_addr"}, 32'(data_addr), 32'd0);
        chk({tag, "_data_wdata"}, data_writedata, 32'd0);
    endtask

    task automatic run_seq(input bit extra_starts, output int lat);
        int nw, exp_lat, exp_polls;
        logic [1:0] ec;
        bit seen;
        logic [31:0] ctrl_exp [3];
        ctrl_exp[0] = 32'hFF7F_FFFF; ctrl_exp[1] = 32'hFF1F_FFFF; ctrl_exp[2] = 32'hFFFF_FFFF;
        model(nw, ec, exp_lat, exp_polls);
        @(negedge clk); #2;
        clear_logs();
        start = 1'b1;
        @(negedge clk); #2;
        start = 1'b0;
        seen = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk); #2;
            if (done_cnt > 0) begin seen = 1; break; end
            start = (extra_starts && $urandom_range(0, 3) == 0);
        end
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        chk("done_seen", 32'(seen), 32'd1);
        chk("done_pulses", done_cnt, 32'd1);
        chk("csr_writes", csr_log.size(), 32'd3);
        for (int i = 0; i < csr_log.size() && i < 3; i++) chk("csr_data", csr_log[i], ctrl_exp[i]);
        chk("n_writes", dw_addr_log.size(), nw);
        for (int i = 0; i < dw_addr_log.size() && i < 6; i++) begin
            chk("wr_addr", 32'(dw_addr_log[i]), 32'(i));
            chk("wr_data", dw_data_log[i], wv[i]);
        end
        chk("err_code", 32'(ec_at_done), 32'(ec));
        chk("error", 32'(err_at_done), 32'(ec != 2'b00));
        chk("err_code_held", 32'(err_code), 32'(ec));
        chk("error_held", 32'(error), 32'(ec != 2'b00));
        chk("latency", seq_cyc, exp_lat);
        chk("polls", n_polls, exp_polls);
        chk("busy_idle", 32'(busy), 32'd0);
        lat = seq_cyc;
    endtask

    initial begin
        int lat;
        bit seen;
        set_good();
        repeat (3) @(negedge clk);
        #2;
        check_rst("por");
        reset_n = 1'b1;

        set_good();
        run_seq(0, lat);
        chk("lat_basic", lat, 32'd24);

        set_good(); cfg_wait[2] = 3;
        run_seq(0, lat);
        chk("lat_wait", lat, 32'd27);
        chk("hold_word2", hold2, 32'd4);

        set_good(); cfg_eok = 0; cfg_ebusy = 2;
        run_seq(0, lat);
        chk("lat_erase_fail", lat, 32'd10);
        chk("erase_fail_code", 32'(ec_at_done), 32'd1);
        chk("erase_fail_nowr", dw_addr_log.size(), 32'd0);

        set_good(); cfg_stuck = 1;
        run_seq(0, lat);
        chk("timeout_polls", n_polls, 32'd16);
        chk("timeout_code", 32'(err_code), 32'd3);
        chk("timeout_prot", (csr_log.size() > 0) ? csr_log[csr_log.size() - 1] : 32'h0, 32'hFFFF_FFFF);

        set_good(); cfg_wok[4] = 0; cfg_wbusy[4] = 2;
        run_seq(0, lat);
        chk("wfail_writes", dw_addr_log.size(), 32'd5);
        chk("wfail_code", 32'(err_code), 32'd2);

        set_good(); cfg_ebusy = 3; cfg_wait[1] = 2;
        run_seq(1, lat);

        // Reset while word 3 is being written
        set_good(); cfg_wait[3] = 5;
        @(negedge clk); #2;
        clear_logs();
        start = 1'b1;
        @(negedge clk); #2;
        start = 1'b0;
        seen = 0;
        for (int c = 0; c < 500; c++) begin
            @(negedge clk); #2;
            if (dw_addr_log.size() == 3 && data_write) begin seen = 1; break; end
        end
        chk("reach_word3", 32'(seen), 32'd1);
        reset_n = 1'b0;
        #1;
        check_rst("mid_rst");
        repeat (2) @(negedge clk);
        #2;
        chk("no_prot", csr_log.size(), 32'd2);
        reset_n = 1'b1;
        set_good();
        run_seq(0, lat);
        chk("lat_after_rst", lat, 32'd24);

        for (int r = 0; r < 25; r++) begin
            set_random();
            run_seq(r[0], lat);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
